// File: rtl/falafel_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// falafel_fifo_stream_reader
//
// Drain-side adapter for falafel_fifo. It pops entries through the FIFO's
// read/empty/dout interface and presents them downstream as a valid/ready
// stream. The stream outputs come straight from registers. A two-entry
// output/skid buffer keeps m_ready_i off the combinational path to
// fifo_read_o. A flush discards everything buffered and drains the FIFO.
// Wrapping counters track delivered beats and flushed (dropped) entries.
//
// Parameters:
//   DATA_W       entry width, must match the attached falafel_fifo
//   CNT_W        width of the beat and drop counters
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   fifo_empty_i FIFO empty flag; when low, fifo_data_i is the head entry
//   fifo_data_i  FIFO head entry
//   fifo_read_o  pops the FIFO head at the clock edge
//   m_valid_o    output entry valid (registered)
//   m_ready_i    downstream accepts
//   m_data_o     output entry (registered)
//   flush_i      discard buffered entries and drain the FIFO while high
//   busy_o       an entry is held in the output or skid register
//   beat_cnt_o   delivered handshakes, wrapping
//   drop_cnt_o   entries discarded by flush, wrapping
// ---------------------------------------------------------------------------
module falafel_fifo_stream_reader #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fifo_empty_i,
   input  logic [DATA_W-1:0] fifo_data_i,
   output logic              fifo_read_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   input  logic              flush_i,
   output logic              busy_o,
   output logic [CNT_W-1:0]  beat_cnt_o,
   output logic [CNT_W-1:0]  drop_cnt_o
);

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              skid_valid_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CNT_W-1:0]  beat_cnt_q;
   logic [CNT_W-1:0]  drop_cnt_q;

   logic              pop;
   logic              take;
   logic              held_drop;
   logic [1:0]        drop_inc;

   // Pop decision. In normal mode we only pop while the skid is free, so
   // there is always somewhere to put the popped entry regardless of what
   // downstream does this cycle; that is what keeps m_ready_i out of this
   // path. During flush every available entry is pulled and thrown away.
   always_comb begin
      pop = 1'b0;
      if (flush_i) begin
         pop = !fifo_empty_i;
      end else begin
         pop = !fifo_empty_i && !skid_valid_q;
      end
   end

   // Entries discarded by a flush this cycle: the skid entry, the output
   // entry unless it is being handed over anyway, and whatever is popped.
   always_comb begin
      take      = out_valid_q && m_ready_i;
      held_drop = out_valid_q && !m_ready_i;
      drop_inc  = {1'b0, skid_valid_q} + {1'b0, held_drop} + {1'b0, pop};
   end

   // Output/skid buffer. The output register is refilled from the skid
   // first (it holds the older entry) and from the FIFO only when the skid
   // is empty. While the output is held, a pop lands in the skid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else if (flush_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (out_valid_q && !take) begin
         if (!skid_valid_q && pop) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= fifo_data_i;
         end
      end else if (skid_valid_q) begin
         out_data_q   <= skid_data_q;
         skid_valid_q <= 1'b0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_data_q  <= fifo_data_i;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   // Delivered and dropped counters. A handshake on a flush cycle still
   // counts as delivered; both counters simply wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (take) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
         end
         if (flush_i) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(drop_inc);
         end
      end
   end

   assign fifo_read_o = pop;
   assign m_valid_o   = out_valid_q;
   assign m_data_o    = out_data_q;
   assign busy_o      = out_valid_q | skid_valid_q;
   assign beat_cnt_o  = beat_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule
